// File: rtl/cpu_seq_pkg.sv
// rtl/cpu_seq_pkg.sv - shared types and defaults for the CPU run sequencer
// Purpose: sequencer state enum, default widths/depth and the saturating
// cycle-counter maximum helper.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_REPORT,
    S_FINISH
  } seq_state_e;

  localparam int ADDR_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int CNT_W_DEF  = 15;

  // Largest value a w-bit counter can hold; the run counter sticks here.
  function automatic logic [63:0] cnt_sat_max(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/seq_addr_queue.sv
// rtl/seq_addr_queue.sv - DEPTH x ADDR_W start-address store with push, indexed read and flush
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (empties the queue)
//   push, push_addr append push_addr at index count when not full
//   flush           empty the queue (wins over push)
//   rd_idx, rd_addr combinational read of entry rd_idx
//   count, full     number of stored entries, count == DEPTH
module seq_addr_queue
  import cpu_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              flush,
  input  logic [IW-1:0]     rd_idx,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [IW:0]       count,
  output logic              full
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic              accept;

  assign full    = (count == (IW+1)'(DEPTH));
  assign accept  = push && !full && !flush;
  assign rd_addr = mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (accept) begin
      count <= count + (IW+1)'(1);
    end
  end

  // Data words need no reset: only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[count[IW-1:0]] <= push_addr;
    end
  end

endmodule

// File: rtl/cpu_run_sequencer.sv
// rtl/cpu_run_sequencer.sv - batch launcher: queues start addresses and runs them back-to-back on the CPU
// Ports:
//   clock_i, reset_ni           clock, asynchronous active-low reset
//   push_i, push_addr_i         enqueue a start address (IDLE only)
//   go_i, abort_i               start the batch / abandon it and flush the queue
//   cpu_start_o, cpu_start_addr_o, cpu_done_i   CPU start/done handshake
//   full_o, count_o, busy_o     queue and batch status
//   result_*_o                  per-run report (valid is a one-cycle strobe)
//   batch_done_o                one-cycle strobe after the last report
module cpu_run_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 0,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic              go_i,
  input  logic              abort_i,
  output logic              cpu_start_o,
  output logic [ADDR_W-1:0] cpu_start_addr_o,
  input  logic              cpu_done_i,
  output logic              full_o,
  output logic [IW:0]       count_o,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic [IW-1:0]     result_idx_o,
  output logic [CNT_W-1:0]  result_cycles_o,
  output logic              result_timeout_o,
  output logic              batch_done_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat_max(CNT_W));

  seq_state_e        state, state_nx;
  logic [IW-1:0]     idx;
  logic [CNT_W-1:0]  cnt, cnt_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic              q_push, q_flush;
  logic              timeout_hit, run_end, last_run;

  seq_addr_queue #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk      (clock_i),
    .rst_n    (reset_ni),
    .push     (q_push),
    .push_addr(push_addr_i),
    .flush    (q_flush),
    .rd_idx   (idx),
    .rd_addr  (rd_addr),
    .count    (count_o),
    .full     (full_o)
  );

  assign q_push  = push_i && (state == S_IDLE);
  assign q_flush = abort_i || (state == S_FINISH);

  assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_inc) == 32'(TIMEOUT));
  assign run_end     = cpu_done_i || timeout_hit;
  assign last_run    = ({1'b0, idx} == count_o - (IW+1)'(1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (go_i && !push_i && count_o != '0) state_nx = S_LAUNCH;
      // done is not looked at in LAUNCH so a level left over from the
      // previous run cannot complete this one.
      S_LAUNCH: state_nx = S_RUN;
      S_RUN:    if (run_end) state_nx = S_REPORT;
      S_REPORT: state_nx = last_run ? S_FINISH : S_LAUNCH;
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    if (abort_i && state != S_IDLE) state_nx = S_IDLE;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state            <= S_IDLE;
      idx              <= '0;
      cnt              <= '0;
      result_idx_o     <= '0;
      result_cycles_o  <= '0;
      result_timeout_o <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE:   idx <= '0;
        S_LAUNCH: cnt <= '0;
        S_RUN: begin
          cnt <= cnt_inc;
          // Result registers load on entry to REPORT and hold until the next one.
          if (run_end && !abort_i) begin
            result_idx_o     <= idx;
            result_cycles_o  <= cnt_inc;
            result_timeout_o <= !cpu_done_i;
          end
        end
        S_REPORT: if (state_nx == S_LAUNCH) idx <= idx + IW'(1);
        default: ;
      endcase
    end
  end

  assign cpu_start_o      = (state == S_LAUNCH) && !abort_i;
  assign cpu_start_addr_o = (state == S_LAUNCH || state == S_RUN) ? rd_addr : '0;
  assign busy_o           = (state != S_IDLE);
  assign result_valid_o   = (state == S_REPORT) && !abort_i;
  assign batch_done_o     = (state == S_FINISH) && !abort_i;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// tb/tb_cpu_run_sequencer.sv - scoreboard bench for cpu_run_sequencer, TIMEOUT=0 and TIMEOUT=50 side by side
module tb_cpu_run_sequencer;

  typedef struct {
    int dut;
    int a;
    int b;
    int c;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       push, go, abort;
  logic [7:0] push_addr;

  logic        start [2];
  logic [7:0]  saddr [2];
  logic        done  [2];
  logic        full  [2];
  logic [2:0]  count [2];
  logic        busy  [2];
  logic        rv    [2];
  logic [1:0]  ridx  [2];
  logic [14:0] rcyc  [2];
  logic        rtmo  [2];
  logic        bd    [2];

  ent_t exp_addr[$];
  ent_t exp_res[$];
  int   total = 0;
  int   bad = 0;
  int   bd_cnt [2];
  int   bd_exp [2];
  logic prev_rv [2];
  logic prev_start [2];
  int   mi;

  int   dly_tab [256];
  int   run_cnt [2];
  int   cur_dly [2];
  logic active  [2];

  always #5 clk = ~clk;

  cpu_run_sequencer #(.ADDR_W(8), .DEPTH(4), .CNT_W(15), .TIMEOUT(0)) u_dut0 (
    .clock_i(clk), .reset_ni(rst_n), .push_i(push), .push_addr_i(push_addr),
    .go_i(go), .abort_i(abort), .cpu_start_o(start[0]), .cpu_start_addr_o(saddr[0]),
    .cpu_done_i(done[0]), .full_o(full[0]), .count_o(count[0]), .busy_o(busy[0]),
    .result_valid_o(rv[0]), .result_idx_o(ridx[0]), .result_cycles_o(rcyc[0]),
    .result_timeout_o(rtmo[0]), .batch_done_o(bd[0]));

  cpu_run_sequencer #(.ADDR_W(8), .DEPTH(4), .CNT_W(15), .TIMEOUT(50)) u_dut1 (
    .clock_i(clk), .reset_ni(rst_n), .push_i(push), .push_addr_i(push_addr),
    .go_i(go), .abort_i(abort), .cpu_start_o(start[1]), .cpu_start_addr_o(saddr[1]),
    .cpu_done_i(done[1]), .full_o(full[1]), .count_o(count[1]), .busy_o(busy[1]),
    .result_valid_o(rv[1]), .result_idx_o(ridx[1]), .result_cycles_o(rcyc[1]),
    .result_timeout_o(rtmo[1]), .batch_done_o(bd[1]));

  // Core model: after a start strobe, done rises on RUN cycle dly_tab[addr]
  // and stays high until the next start (0 = never).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        active[k]  <= 1'b0;
        run_cnt[k] <= 0;
        cur_dly[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (start[k]) begin
          active[k]  <= 1'b1;
          run_cnt[k] <= 1;
          cur_dly[k] <= dly_tab[saddr[k]];
        end else if (active[k]) begin
          run_cnt[k] <= run_cnt[k] + 1;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      done[k] = active[k] && (cur_dly[k] != 0) && (run_cnt[k] >= cur_dly[k]);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int find_ent(input ent_t q[$], input int k);
    foreach (q[i]) if (q[i].dut == k) return i;
    return -1;
  endfunction

  function automatic logic [63:0] outs(input int k);
    return 64'({start[k], saddr[k], full[k], count[k], busy[k], rv[k],
                ridx[k], rcyc[k], rtmo[k], bd[k]});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (start[k]) begin
          chk($sformatf("d%0d_start_1cyc", k), 64'(prev_start[k]), 0);
          mi = find_ent(exp_addr, k);
          chk($sformatf("d%0d_start_expected", k), 64'(mi >= 0), 1);
          if (mi >= 0) begin
            chk($sformatf("d%0d_start_addr", k), 64'(saddr[k]), 64'(exp_addr[mi].a));
            exp_addr.delete(mi);
          end
        end
        if (rv[k]) begin
          mi = find_ent(exp_res, k);
          chk($sformatf("d%0d_result_expected", k), 64'(mi >= 0), 1);
          if (mi >= 0) begin
            chk($sformatf("d%0d_result_idx", k), 64'(ridx[k]), 64'(exp_res[mi].a));
            chk($sformatf("d%0d_result_cycles", k), 64'(rcyc[k]), 64'(exp_res[mi].b));
            chk($sformatf("d%0d_result_timeout", k), 64'(rtmo[k]), 64'(exp_res[mi].c));
            exp_res.delete(mi);
          end
        end
        if (bd[k]) begin
          chk($sformatf("d%0d_bd_after_rv", k), 64'(prev_rv[k]), 1);
          bd_cnt[k] <= bd_cnt[k] + 1;
        end
        prev_rv[k]    <= rv[k];
        prev_start[k] <= start[k];
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_push(input int a);
    push = 1'b1;
    push_addr = 8'(a);
    tick(1);
    push = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic exp_start(input logic [1:0] mask, input int a);
    for (int k = 0; k < 2; k++) if (mask[k]) exp_addr.push_back('{k, a, 0, 0});
  endtask

  task automatic exp_result(input logic [1:0] mask, input int idx, input int cyc, input int tmo);
    for (int k = 0; k < 2; k++) if (mask[k]) exp_res.push_back('{k, idx, cyc, tmo});
  endtask

  task automatic exp_batch(input logic [1:0] mask);
    for (int k = 0; k < 2; k++) if (mask[k]) bd_exp[k]++;
  endtask

  task automatic wait_idle(input string tag, input logic [1:0] mask, input int budget);
    int n = 0;
    while (n < budget && ((mask[0] && busy[0]) || (mask[1] && busy[1]))) begin
      tick(1);
      n++;
    end
    for (int k = 0; k < 2; k++) begin
      if (mask[k]) begin
        chk($sformatf("%s_idle_d%0d", tag, k), 64'(busy[k]), 0);
        chk($sformatf("%s_bd_d%0d", tag, k), 64'(bd_cnt[k]), 64'(bd_exp[k]));
      end
    end
  endtask

  task automatic chk_both(input string tag, input int sel, input int exp);
    for (int k = 0; k < 2; k++) begin
      case (sel)
        0: chk($sformatf("%s_count_d%0d", tag, k), 64'(count[k]), 64'(exp));
        1: chk($sformatf("%s_full_d%0d", tag, k), 64'(full[k]), 64'(exp));
        2: chk($sformatf("%s_busy_d%0d", tag, k), 64'(busy[k]), 64'(exp));
        default: chk($sformatf("%s_start_d%0d", tag, k), 64'(start[k]), 64'(exp));
      endcase
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    push = 1'b0; go = 1'b0; abort = 1'b0; push_addr = '0;
    for (int i = 0; i < 256; i++) dly_tab[i] = 0;
    for (int k = 0; k < 2; k++) begin
      bd_cnt[k] = 0; bd_exp[k] = 0; prev_rv[k] = 1'b0; prev_start[k] = 1'b0;
    end
    #2 rst_n = 1'b0;
    #10;
    for (int k = 0; k < 2; k++) chk($sformatf("reset_outs_d%0d", k), outs(k), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(1);

    // Single run, done 37 cycles after start.
    dly_tab[100] = 37;
    do_push(100);
    chk_both("t1_push", 0, 1);
    exp_start(3, 100); exp_result(3, 0, 37, 0); exp_batch(3);
    pulse_go();
    chk_both("t1_go", 2, 1);
    wait_idle("t1", 3, 200);

    // Three runs, done left high between runs.
    dly_tab[93] = 5; dly_tab[138] = 12;
    do_push(100); do_push(93); do_push(138);
    chk_both("t2_push", 0, 3);
    exp_start(3, 100); exp_start(3, 93); exp_start(3, 138);
    exp_result(3, 0, 37, 0); exp_result(3, 1, 5, 0); exp_result(3, 2, 12, 0); exp_batch(3);
    pulse_go();
    wait_idle("t2", 3, 400);

    // Never-done core: only the TIMEOUT=50 instance gives up.
    dly_tab[20] = 0;
    do_push(20);
    exp_start(3, 20); exp_result(2, 0, 50, 1); exp_batch(2);
    pulse_go();
    wait_idle("t3a", 2, 200);
    chk("t3_d0_still_running", 64'(busy[0]), 1);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk_both("t3_abort", 2, 0);
    chk_both("t3_abort", 0, 0);

    // Done on RUN cycle 50 beats the timeout; a 60-cycle run only times out at 50.
    dly_tab[21] = 50; dly_tab[22] = 60;
    do_push(21); do_push(22);
    exp_start(3, 21); exp_start(3, 22);
    exp_result(3, 0, 50, 0); exp_result(1, 1, 60, 0); exp_result(2, 1, 50, 1); exp_batch(3);
    pulse_go();
    wait_idle("t3b", 3, 300);

    // Queue limits.
    for (int a = 1; a <= 5; a++) dly_tab[a] = 3;
    for (int a = 1; a <= 4; a++) begin
      do_push(a);
      chk_both($sformatf("t4_push%0d", a), 0, a);
      chk_both($sformatf("t4_push%0d", a), 1, (a == 4) ? 1 : 0);
    end
    do_push(5);
    chk_both("t4_push5", 0, 4);
    chk_both("t4_push5", 1, 1);
    for (int a = 1; a <= 4; a++) begin
      exp_start(3, a);
      exp_result(3, a - 1, 3, 0);
    end
    exp_batch(3);
    pulse_go();
    wait_idle("t4", 3, 200);
    chk_both("t4_after", 0, 0);
    pulse_go();
    tick(3);
    chk_both("t4_go_empty", 2, 0);

    // Abort during the second of three runs; a push in RUN is ignored.
    dly_tab[40] = 20; dly_tab[41] = 20; dly_tab[42] = 20;
    do_push(40); do_push(41); do_push(42);
    exp_start(3, 40); exp_start(3, 41); exp_result(3, 0, 20, 0);
    pulse_go();
    n = 0;
    while (n < 200 && !(start[0] && saddr[0] == 8'd41)) begin
      tick(1);
      n++;
    end
    chk("t5_second_start", 64'(start[0]), 1);
    tick(3);
    do_push(77);
    chk_both("t5_push_in_run", 0, 3);
    chk_both("t5_in_run", 2, 1);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk_both("t5_abort", 2, 0);
    chk_both("t5_abort", 0, 0);
    chk_both("t5_abort", 3, 0);
    tick(60);
    chk("t5_bd_d0", 64'(bd_cnt[0]), 64'(bd_exp[0]));
    chk("t5_bd_d1", 64'(bd_cnt[1]), 64'(bd_exp[1]));

    // Asynchronous reset in the middle of a run.
    dly_tab[50] = 30; dly_tab[51] = 4;
    do_push(50);
    exp_start(3, 50);
    pulse_go();
    tick(5);
    chk_both("t6_pre_reset", 2, 1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk($sformatf("t6_async_outs_d%0d", k), outs(k), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    do_push(51);
    exp_start(3, 51); exp_result(3, 0, 4, 0); exp_batch(3);
    pulse_go();
    wait_idle("t6", 3, 100);

    tick(2);
    chk("exp_res_left", 64'(exp_res.size()), 0);
    chk("exp_addr_left", 64'(exp_addr.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
